// File: rtl/leaf_result_drain.sv
// rtl/leaf_result_drain.sv - buffers up to three leaf results per commit slot and drains them one per handshake
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   clear      synchronous restart for the next tree (same effect as reset)
//   strobe     schedule commit slot; res_a/res_b/res_c sampled only when high
//   res_a/b/c  leaf result words; a nonzero word is a valid result
//   out_data   head word of the buffer, 0 when empty
//   out_valid  buffer non-empty
//   out_ready  consumer accepts out_data this cycle
//   out_last   presented word is the LEAF_COUNT-th word of the tree
//   overflow   sticky: a valid input word was dropped
//   done       sticky: the last word of the tree has been transferred
module leaf_result_drain #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 8,
    parameter int LEAF_COUNT = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              strobe,
    input  logic [DATA_W-1:0] res_a,
    input  logic [DATA_W-1:0] res_b,
    input  logic [DATA_W-1:0] res_c,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              overflow,
    output logic              done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_DONE    = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [7:0]        accepted;
    logic [7:0]        sent;
    logic              overflow_q;

    logic              pop;
    logic              collecting;
    logic [31:0]       free_slots;
    logic [31:0]       leaf_room;
    logic [31:0]       budget;
    logic [1:0]        n_push;
    logic              drop;
    logic              we_a;
    logic              we_b;
    logic              we_c;
    logic [AW-1:0]     idx_a;
    logic [AW-1:0]     idx_b;
    logic [AW-1:0]     idx_c;
    logic [8:0]        accepted_sum;

    // Read side: everything presented depends only on registered state.
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign out_last  = out_valid && (sent == 8'(LEAF_COUNT - 1));
    assign pop       = out_valid && out_ready;
    assign overflow  = overflow_q;
    assign done      = (state == S_DONE);

    // Push allocation. Space is judged on the count before this edge, so a
    // pop on the same edge never frees a slot for the incoming words.
    always_comb begin
        collecting = (state == S_COLLECT) && strobe && !clear;
        free_slots = 32'(DEPTH) - 32'(count);
        leaf_room  = 32'(LEAF_COUNT) - 32'(accepted);
        budget     = (free_slots < leaf_room) ? free_slots : leaf_room;
        n_push     = 2'd0;
        drop       = 1'b0;
        we_a       = 1'b0;
        we_b       = 1'b0;
        we_c       = 1'b0;
        idx_a      = wr_ptr;
        idx_b      = wr_ptr;
        idx_c      = wr_ptr;

        // Valid words pack into consecutive slots in a, b, c order; zero
        // words leave no gap. Anything past the budget is dropped.
        if (collecting && (res_a != '0)) begin
            if (32'(n_push) < budget) begin
                we_a   = 1'b1;
                idx_a  = wr_ptr + AW'(n_push);
                n_push = n_push + 2'd1;
            end else begin
                drop = 1'b1;
            end
        end
        if (collecting && (res_b != '0)) begin
            if (32'(n_push) < budget) begin
                we_b   = 1'b1;
                idx_b  = wr_ptr + AW'(n_push);
                n_push = n_push + 2'd1;
            end else begin
                drop = 1'b1;
            end
        end
        if (collecting && (res_c != '0)) begin
            if (32'(n_push) < budget) begin
                we_c   = 1'b1;
                idx_c  = wr_ptr + AW'(n_push);
                n_push = n_push + 2'd1;
            end else begin
                drop = 1'b1;
            end
        end

        accepted_sum = 9'(accepted) + 9'(n_push);
    end

    // Storage array carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (we_a) mem[idx_a] <= res_a;
        if (we_b) mem[idx_b] <= res_b;
        if (we_c) mem[idx_c] <= res_c;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            accepted   <= '0;
            sent       <= '0;
            overflow_q <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            accepted   <= '0;
            sent       <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(n_push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(n_push) - CW'(pop);
            if (accepted_sum > 9'(LEAF_COUNT)) begin
                accepted <= 8'(LEAF_COUNT);
            end else begin
                accepted <= accepted_sum[7:0];
            end
            if (pop && (sent != 8'(LEAF_COUNT))) begin
                sent <= sent + 8'd1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // The tree finishes when its last word leaves; only clear/reset restart.
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = S_COLLECT;
        end else if ((state == S_COLLECT) && pop && out_last) begin
            state_nxt = S_DONE;
        end
    end

endmodule

// File: tb/tb_leaf_result_drain.sv
// tb/tb_leaf_result_drain.sv - directed self-checking bench for leaf_result_drain
module tb_leaf_result_drain;

    logic        clk;
    logic        reset;
    logic        clr     [3];
    logic        stb     [3];
    logic [31:0] ra      [3];
    logic [31:0] rb      [3];
    logic [31:0] rc      [3];
    logic [31:0] od      [3];
    logic        ov      [3];
    logic        rdy     [3];
    logic        ol      [3];
    logic        ovf     [3];
    logic        dn      [3];

    int n_cmp;
    int n_err;

    // Instance 0: LEAF_COUNT=7, instance 1: LEAF_COUNT=16 (buffer-limited),
    // instance 2: LEAF_COUNT=2 (leaf-count-limited).
    leaf_result_drain #(.DATA_W(32), .DEPTH(8), .LEAF_COUNT(7)) u_dut0 (
        .clk(clk), .reset(reset), .clear(clr[0]), .strobe(stb[0]),
        .res_a(ra[0]), .res_b(rb[0]), .res_c(rc[0]),
        .out_data(od[0]), .out_valid(ov[0]), .out_ready(rdy[0]),
        .out_last(ol[0]), .overflow(ovf[0]), .done(dn[0])
    );

    leaf_result_drain #(.DATA_W(32), .DEPTH(8), .LEAF_COUNT(16)) u_dut1 (
        .clk(clk), .reset(reset), .clear(clr[1]), .strobe(stb[1]),
        .res_a(ra[1]), .res_b(rb[1]), .res_c(rc[1]),
        .out_data(od[1]), .out_valid(ov[1]), .out_ready(rdy[1]),
        .out_last(ol[1]), .overflow(ovf[1]), .done(dn[1])
    );

    leaf_result_drain #(.DATA_W(32), .DEPTH(8), .LEAF_COUNT(2)) u_dut2 (
        .clk(clk), .reset(reset), .clear(clr[2]), .strobe(stb[2]),
        .res_a(ra[2]), .res_b(rb[2]), .res_c(rc[2]),
        .out_data(od[2]), .out_valid(ov[2]), .out_ready(rdy[2]),
        .out_last(ol[2]), .overflow(ovf[2]), .done(dn[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        stb[d] = 1'b1;
        ra[d]  = a;
        rb[d]  = b;
        rc[d]  = c;
        tick();
        stb[d] = 1'b0;
        ra[d]  = '0;
        rb[d]  = '0;
        rc[d]  = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            clr[d] = 1'b0;
            stb[d] = 1'b0;
            ra[d]  = '0;
            rb[d]  = '0;
            rc[d]  = '0;
            rdy[d] = 1'b0;
        end
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Reset state
        check("rst_valid", 32'(ov[0]), 32'd0);
        check("rst_data", od[0], 32'd0);
        check("rst_last", 32'(ol[0]), 32'd0);
        check("rst_ovf", 32'(ovf[0]), 32'd0);
        check("rst_done", 32'(dn[0]), 32'd0);

        // Basic order with a consumer that is always ready
        rdy[0] = 1'b1;
        push(0, 32'h11, 32'h00, 32'h33);
        check("ord_11", od[0], 32'h11);
        check("ord_11_v", 32'(ov[0]), 32'd1);
        push(0, 32'h44, 32'h55, 32'h66);
        check("ord_33", od[0], 32'h33);
        push(0, 32'h00, 32'h77, 32'h00);
        check("ord_44", od[0], 32'h44);
        tick();
        check("ord_55", od[0], 32'h55);
        tick();
        check("ord_66", od[0], 32'h66);
        tick();
        check("ord_77", od[0], 32'h77);
        check("ord_77_last", 32'(ol[0]), 32'd0);
        tick();
        check("ord_empty_v", 32'(ov[0]), 32'd0);
        check("ord_empty_d", od[0], 32'd0);
        push(0, 32'h88, 32'h00, 32'h00);
        check("ord_88", od[0], 32'h88);
        check("ord_88_last", 32'(ol[0]), 32'd1);
        check("ord_88_done", 32'(dn[0]), 32'd0);
        tick();
        check("ord_done", 32'(dn[0]), 32'd1);
        check("ord_done_v", 32'(ov[0]), 32'd0);
        push(0, 32'h12, 32'h00, 32'h00);
        check("done_ign_v", 32'(ov[0]), 32'd0);
        check("done_ign_ovf", 32'(ovf[0]), 32'd0);
        check("done_hold", 32'(dn[0]), 32'd1);

        // Clear after done, then a full tree under backpressure
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        check("clr_done", 32'(dn[0]), 32'd0);
        rdy[0] = 1'b0;
        push(0, 32'd1, 32'd2, 32'd3);
        push(0, 32'd4, 32'd5, 32'd6);
        push(0, 32'd7, 32'd0, 32'd0);
        check("clr_ovf", 32'(ovf[0]), 32'd0);
        rdy[0] = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            check($sformatf("tree2_w%0d", i), od[0], 32'(i));
            check($sformatf("tree2_l%0d", i), 32'(ol[0]), (i == 7) ? 32'd1 : 32'd0);
            tick();
        end
        check("tree2_done", 32'(dn[0]), 32'd1);

        // Over-count with LEAF_COUNT=2
        push(2, 32'd5, 32'd6, 32'd7);
        check("oc_ovf", 32'(ovf[2]), 32'd1);
        check("oc_w5", od[2], 32'd5);
        check("oc_l5", 32'(ol[2]), 32'd0);
        rdy[2] = 1'b1;
        tick();
        check("oc_w6", od[2], 32'd6);
        check("oc_l6", 32'(ol[2]), 32'd1);
        tick();
        check("oc_done", 32'(dn[2]), 32'd1);
        check("oc_empty", 32'(ov[2]), 32'd0);
        push(2, 32'd3, 32'd0, 32'd0);
        check("oc_ign", 32'(ov[2]), 32'd0);

        // Backpressure to full, buffer-limited instance
        push(1, 32'd1, 32'd2, 32'd3);
        push(1, 32'd4, 32'd5, 32'd6);
        check("bp_ovf0", 32'(ovf[1]), 32'd0);
        push(1, 32'd7, 32'd8, 32'd9);
        check("bp_ovf1", 32'(ovf[1]), 32'd1);
        check("bp_head", od[1], 32'd1);
        // Full, simultaneous pop and push: push still dropped
        rdy[1] = 1'b1;
        push(1, 32'hA, 32'h0, 32'h0);
        check("sim_head", od[1], 32'd2);
        check("sim_ovf", 32'(ovf[1]), 32'd1);
        for (int v = 2; v <= 8; v++) begin
            check($sformatf("drain_%0d", v), od[1], 32'(v));
            tick();
        end
        check("drain_empty", 32'(ov[1]), 32'd0);
        check("drain_nolast", 32'(ol[1]), 32'd0);

        // Reset mid-stream
        rdy[1] = 1'b0;
        push(1, 32'h21, 32'h22, 32'h23);
        push(1, 32'h24, 32'h00, 32'h00);
        check("rm_pre_v", 32'(ov[1]), 32'd1);
        reset = 1'b0;
        #1;
        check("rm_async_v", 32'(ov[1]), 32'd0);
        tick();
        reset = 1'b1;
        check("rm_data", od[1], 32'd0);
        check("rm_ovf", 32'(ovf[1]), 32'd0);
        check("rm_done", 32'(dn[1]), 32'd0);
        check("rm_done0", 32'(dn[0]), 32'd0);
        push(1, 32'h99, 32'h00, 32'h00);
        check("rm_99", od[1], 32'h99);
        check("rm_99_v", 32'(ov[1]), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/leaf_result_drain.md
# leaf_result_drain

Collects the 32-bit leaf results emitted by the leaf-producing PEs (three result ports per schedule slot) and serialises them into a single valid/ready output stream for readout. It sits downstream of the tree scheduler and is the reader end of the leaf-result path: the scheduler's commit slot writes up to three words per slot, and this block buffers them in arrival order and releases them one per handshake. It marks the final leaf of a tree and signals completion.

## Interface
- DATA_W, 32, width of one leaf result word
- DEPTH, 8, buffer entries; power of two, ≥ 4
- LEAF_COUNT, 7, leaves per tree; 1..255

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- clear  in  1  synchronous restart for the next tree; same effect as reset
- strobe  in  1  schedule commit slot; res_* are sampled only when 1
- res_a  in  DATA_W  first leaf result; nonzero means valid
- res_b  in  DATA_W  second leaf result; nonzero means valid
- res_c  in  DATA_W  third leaf result; nonzero means valid
- out_data  out  DATA_W  head word; 0 when empty
- out_valid  out  1  buffer non-empty
- out_ready  in  1  consumer accepts out_data this cycle
- out_last  out  1  presented word is the LEAF_COUNT-th word of the tree
- overflow  out  1  sticky: at least one valid input was dropped
- done  out  1  sticky: last word has been transferred

## Operation
- Reset or clear: buffer empty, read/write pointers 0, accepted and sent counters 0, FSM = COLLECT. All outputs 0.
- Push, COLLECT only: on a clk edge with strobe=1, each nonzero input is written in the order a, b, c into consecutive slots. Zero inputs are skipped and leave no gap. Accepted counter += words written.
- Space rule: free = DEPTH − count, using count before this edge. A pop on the same edge does not create push space. Also limited to LEAF_COUNT − accepted. Words beyond either limit are dropped in a/b/c priority order and set overflow. Example: free=1 with a, b, c all valid → a written; b, c dropped.
- Pop: a transfer occurs when out_valid && out_ready. Head pointer advances and sent counter += 1. out_valid=0 blocks a pop regardless of out_ready.
- Simultaneous push and pop: both happen. count_next = count + pushed − popped.
- out_last = out_valid && (sent == LEAF_COUNT − 1).
- FSM states:
  - COLLECT → DONE on the transfer of the out_last word.
  - DONE: done=1, strobe ignored (not flagged as overflow), buffer is empty.
  - DONE → COLLECT only on clear or reset.
- Counter widths: pointers are clog2(DEPTH) bits and wrap modulo DEPTH. count is clog2(DEPTH+1) bits. accepted and sent are 8 bits and saturate at LEAF_COUNT.
- Reset asserted mid-operation: everything clears immediately (asynchronously); buffered words are lost. clear has priority over a push or pop on the same edge.

## Timing
- Push-to-output latency is 1 cycle. A word written at edge N appears on out_data/out_valid after edge N. There is no combinational path from res_*/strobe to any output.
- out_data, out_valid and out_last depend only on registered state and are stable for the whole cycle. out_ready is sampled at the edge.
- Throughput is 1 word per cycle out, and up to 3 words per strobe in.
- done and overflow assert the cycle after their triggering edge and hold until clear or reset.
- Full condition: count == DEPTH → out_valid=1, and every push is dropped with overflow.

## Test plan
- Basic order: LEAF_COUNT=7, out_ready=1. Strobe 1: a=0x11, b=0, c=0x33. Strobe 2: a=0x44, b=0x55, c=0x66. Strobe 3: b=0x77. Required output sequence: 0x11, 0x33, 0x44, 0x55, 0x66, 0x77 with out_last=0, then 0x77's successor absent. Extend to a 7th word 0x88 → out_last=1 on 0x88 only; done=1 the next cycle.
- Backpressure/full: DEPTH=8, out_ready=0. Three strobes, each with a, b, c = 1..9 → count=8 and overflow=1. The 9th word (value 9) is dropped even if out_ready rises on the same edge. Drain yields 1..8.
- Simultaneous push/pop: count=8 held, out_ready=1, strobe with a=0xA → head popped, 0xA dropped, overflow=1, count=7.
- Over-count: LEAF_COUNT=2. Strobe a=5, b=6, c=7 → 7 dropped, overflow=1. Output 5, then 6 with out_last=1. Afterwards done=1 and further strobes are ignored.
- Reset mid-stream: 4 words buffered, reset pulses low for 1 cycle → out_valid=0, out_data=0, overflow=0, done=0. New strobe a=0x99 → 0x99 is presented the next cycle.
- Clear after done: clear=1 for one edge → done=0. A new tree of 7 words is accepted and output normally.
